// File: rtl/iq_entry_alloc.sv
`timescale 1ns/1ps
// iq_entry_alloc
//   Free-list owner for the issue queue. Offers the two lowest free entry
//   indices to dispatch each cycle. Entries are reclaimed when one of the
//   three select ports issues them, and when a misprediction squashes them.
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   req_1, req_2, stall_DP          dispatch slot requests and stall
//   grant1..3, selected_ent_1..3    select-port issue notifications
//   prmiss, flush_vec               misprediction squash of entries
//   iq_entry_num_1/2                lowest / second-lowest free entry
//   invalid1/2                      slot not allocated this cycle
//   allocatable_IQ                  two or more entries free
//   free_cnt                        registered free-entry count
//   alloc_err                       sticky protocol error flag
//
// Build option
//   IQ_ENTRY_ALLOC_CHECK_EN : when defined, alloc_err latches on a double
//   free, a flush_vec bit without prmiss, or a request made while not
//   allocatable. When undefined, alloc_err is tied low.

module iq_entry_alloc #(
  parameter int IQ_ENT_NUM = 16,
  parameter int IQ_ENT_SEL = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_1,
  input  logic                  req_2,
  input  logic                  stall_DP,
  input  logic                  grant1,
  input  logic                  grant2,
  input  logic                  grant3,
  input  logic [IQ_ENT_SEL-1:0] selected_ent_1,
  input  logic [IQ_ENT_SEL-1:0] selected_ent_2,
  input  logic [IQ_ENT_SEL-1:0] selected_ent_3,
  input  logic                  prmiss,
  input  logic [IQ_ENT_NUM-1:0] flush_vec,
  output logic [IQ_ENT_SEL-1:0] iq_entry_num_1,
  output logic [IQ_ENT_SEL-1:0] iq_entry_num_2,
  output logic                  invalid1,
  output logic                  invalid2,
  output logic                  allocatable_IQ,
  output logic [IQ_ENT_SEL:0]   free_cnt,
  output logic                  alloc_err
);

  logic [IQ_ENT_NUM-1:0] free_vec_q, free_vec_d;
  logic [IQ_ENT_SEL:0]   free_cnt_q, free_cnt_d;
  logic [IQ_ENT_SEL-1:0] ent1, ent2;
  logic                  found1, found2;
  logic                  commit;
  logic [IQ_ENT_NUM-1:0] alloc_mask, free_mask, flush_mask;

  // Two-deep priority pick; an index with no free entry behind it stays 0.
  always_comb begin
    ent1   = '0;
    ent2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int i = 0; i < IQ_ENT_NUM; i++) begin
      if (free_vec_q[i]) begin
        if (!found1) begin
          ent1   = IQ_ENT_SEL'(i);
          found1 = 1'b1;
        end else if (!found2) begin
          ent2   = IQ_ENT_SEL'(i);
          found2 = 1'b1;
        end
      end
    end
  end

  assign iq_entry_num_1 = ent1;
  assign iq_entry_num_2 = ent2;
  assign free_cnt       = free_cnt_q;
  assign allocatable_IQ = (free_cnt_q >= (IQ_ENT_SEL+1)'(2));

  // All-or-nothing: with a single free entry neither slot is served, so a
  // slot-2 request never depends on whether slot 1 was used.
  assign commit   = ~stall_DP & ~prmiss & allocatable_IQ;
  assign invalid1 = ~(req_1 & commit);
  assign invalid2 = ~(req_2 & commit);

  always_comb begin
    alloc_mask = '0;
    if (commit & req_1) alloc_mask[ent1] = 1'b1;
    if (commit & req_2) alloc_mask[ent2] = 1'b1;

    free_mask = '0;
    if (grant1) free_mask[selected_ent_1] = 1'b1;
    if (grant2) free_mask[selected_ent_2] = 1'b1;
    if (grant3) free_mask[selected_ent_3] = 1'b1;

    flush_mask = prmiss ? flush_vec : '0;

    // Frees only land at the edge, so they are never offered the same cycle.
    free_vec_d = (free_vec_q & ~alloc_mask) | free_mask | flush_mask;

    free_cnt_d = '0;
    for (int i = 0; i < IQ_ENT_NUM; i++) begin
      free_cnt_d = free_cnt_d + {{IQ_ENT_SEL{1'b0}}, free_vec_d[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_vec_q <= '1;
      free_cnt_q <= (IQ_ENT_SEL+1)'(IQ_ENT_NUM);
    end else begin
      free_vec_q <= free_vec_d;
      free_cnt_q <= free_cnt_d;
    end
  end

`ifdef IQ_ENTRY_ALLOC_CHECK_EN
  logic alloc_err_q, alloc_err_d, proto_viol;

  always_comb begin
    proto_viol = (grant1 & free_vec_q[selected_ent_1])
               | (grant2 & free_vec_q[selected_ent_2])
               | (grant3 & free_vec_q[selected_ent_3])
               | (~prmiss & (|flush_vec))
               | ((req_1 | req_2) & ~stall_DP & ~allocatable_IQ);
    alloc_err_d = alloc_err_q | proto_viol;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alloc_err_q <= 1'b0;
    else          alloc_err_q <= alloc_err_d;
  end

  assign alloc_err = alloc_err_q;
`else
  assign alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_iq_entry_alloc.sv
`timescale 1ns/1ps
module tb_iq_entry_alloc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_1, req_2, stall_DP;
  logic        grant1, grant2, grant3;
  logic [3:0]  selected_ent_1, selected_ent_2, selected_ent_3;
  logic        prmiss;
  logic [15:0] flush_vec;
  logic [3:0]  iq_entry_num_1, iq_entry_num_2;
  logic        invalid1, invalid2, allocatable_IQ;
  logic [4:0]  free_cnt;
  logic        alloc_err;

  int tests = 0;
  int fails = 0;

  iq_entry_alloc #(.IQ_ENT_NUM(16), .IQ_ENT_SEL(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_1(req_1), .req_2(req_2), .stall_DP(stall_DP),
    .grant1(grant1), .grant2(grant2), .grant3(grant3),
    .selected_ent_1(selected_ent_1), .selected_ent_2(selected_ent_2),
    .selected_ent_3(selected_ent_3),
    .prmiss(prmiss), .flush_vec(flush_vec),
    .iq_entry_num_1(iq_entry_num_1), .iq_entry_num_2(iq_entry_num_2),
    .invalid1(invalid1), .invalid2(invalid2),
    .allocatable_IQ(allocatable_IQ), .free_cnt(free_cnt),
    .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: set of busy entries; free list built as an ordered queue.
  bit [15:0] m_busy, m_busy_nxt;
  bit        m_err, m_err_nxt;
  int        fq[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= '0;
      m_err  <= 1'b0;
    end else begin
      m_busy <= m_busy_nxt;
      m_err  <= m_err_nxt;
    end
  end

  always @(negedge clk) begin
    int e1, e2;
    bit can, go, viol;
    fq.delete();
    for (int i = 0; i < 16; i++) if (!m_busy[i]) fq.push_back(i);
    e1  = (fq.size() > 0) ? fq[0] : 0;
    e2  = (fq.size() > 1) ? fq[1] : 0;
    can = (fq.size() >= 2);
    go  = !stall_DP && !prmiss && can;

    chk("free_cnt",       free_cnt,       fq.size());
    chk("allocatable_IQ", allocatable_IQ, can);
    chk("iq_entry_num_1", iq_entry_num_1, e1);
    chk("iq_entry_num_2", iq_entry_num_2, e2);
    chk("invalid1",       invalid1,       !(req_1 && go));
    chk("invalid2",       invalid2,       !(req_2 && go));
    chk("alloc_err",      alloc_err,      m_err);

    m_busy_nxt = m_busy;
    if (go && req_1) m_busy_nxt[e1] = 1'b1;
    if (go && req_2) m_busy_nxt[e2] = 1'b1;
    if (grant1) m_busy_nxt[selected_ent_1] = 1'b0;
    if (grant2) m_busy_nxt[selected_ent_2] = 1'b0;
    if (grant3) m_busy_nxt[selected_ent_3] = 1'b0;
    if (prmiss) for (int i = 0; i < 16; i++) if (flush_vec[i]) m_busy_nxt[i] = 1'b0;

    viol = (grant1 && !m_busy[selected_ent_1]) || (grant2 && !m_busy[selected_ent_2]) ||
           (grant3 && !m_busy[selected_ent_3]) || (!prmiss && flush_vec != 0) ||
           ((req_1 || req_2) && !stall_DP && !can);
`ifdef IQ_ENTRY_ALLOC_CHECK_EN
    m_err_nxt = m_err || viol;
`else
    m_err_nxt = 1'b0;
    if (viol) m_err_nxt = 1'b0;
`endif
  end

  task automatic idle();
    req_1 = 0; req_2 = 0; stall_DP = 0;
    grant1 = 0; grant2 = 0; grant3 = 0;
    selected_ent_1 = 0; selected_ent_2 = 0; selected_ent_3 = 0;
    prmiss = 0; flush_vec = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    idle();
    reset_n = 0;
    #1;
    chk("rst free_cnt", free_cnt, 16);
    chk("rst allocatable", allocatable_IQ, 1);
    chk("rst num1", iq_entry_num_1, 0);
    chk("rst num2", iq_entry_num_2, 1);
    chk("rst alloc_err", alloc_err, 0);
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic fill();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      idle(); req_1 = 1; req_2 = 1;
      @(negedge clk);
      chk("fill num1", iq_entry_num_1, 2*k);
      chk("fill num2", iq_entry_num_2, 2*k+1);
      chk("fill invalid1", invalid1, 0);
    end
    @(posedge clk); #1;
    idle(); req_1 = 1; req_2 = 1;
    @(negedge clk);
    chk("full free_cnt", free_cnt, 0);
    chk("full allocatable", allocatable_IQ, 0);
    chk("full invalid1", invalid1, 1);
    chk("full invalid2", invalid2, 1);
  endtask

  initial begin
    idle();
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;

    // Fill, then reset with everything busy.
    fill();
    do_reset();

    // Free three entries from full.
    fill();
    @(posedge clk); #1;
    idle(); req_1 = 1; req_2 = 1;
    grant1 = 1; selected_ent_1 = 4'd5;
    grant2 = 1; selected_ent_2 = 4'd2;
    grant3 = 1; selected_ent_3 = 4'd9;
    @(negedge clk);
    chk("free same-cycle invalid1", invalid1, 1);
    chk("free same-cycle invalid2", invalid2, 1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("free free_cnt", free_cnt, 3);
    chk("free num1", iq_entry_num_1, 2);
    chk("free num2", iq_entry_num_2, 5);

    // Single free entry: no partial allocation.
    do_reset();
    fill();
    @(posedge clk); #1;
    idle(); grant1 = 1; selected_ent_1 = 4'd7;
    @(posedge clk); #1;
    idle(); req_1 = 1;
    @(negedge clk);
    chk("single invalid1", invalid1, 1);
    chk("single num1", iq_entry_num_1, 7);
    chk("single num2", iq_entry_num_2, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("single free_cnt", free_cnt, 1);
    chk("single still num1", iq_entry_num_1, 7);

    // Misprediction flush with a concurrent grant.
    do_reset();
    fill();
    @(posedge clk); #1;
    idle(); prmiss = 1; flush_vec = 16'h00F0;
    grant1 = 1; selected_ent_1 = 4'd12; req_1 = 1; req_2 = 1;
    @(negedge clk);
    chk("flush invalid1", invalid1, 1);
    chk("flush invalid2", invalid2, 1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk("flush free_cnt", free_cnt, 5);
    chk("flush num1", iq_entry_num_1, 4);
    chk("flush num2", iq_entry_num_2, 5);

    // Double free of entry 3.
    do_reset();
    @(posedge clk); #1;
    idle(); grant1 = 1; selected_ent_1 = 4'd3;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
`ifdef IQ_ENTRY_ALLOC_CHECK_EN
    chk("err set", alloc_err, 1);
`else
    chk("err tied", alloc_err, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef IQ_ENTRY_ALLOC_CHECK_EN
    chk("err held", alloc_err, 1);
`else
    chk("err tied held", alloc_err, 0);
`endif
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_1    = ($urandom_range(0, 1) == 1);
      req_2    = ($urandom_range(0, 1) == 1);
      stall_DP = ($urandom_range(0, 7) == 0);
      grant1   = ($urandom_range(0, 2) == 0);
      grant2   = ($urandom_range(0, 2) == 0);
      grant3   = ($urandom_range(0, 3) == 0);
      selected_ent_1 = 4'($urandom_range(0, 15));
      selected_ent_2 = 4'($urandom_range(0, 15));
      selected_ent_3 = 4'($urandom_range(0, 15));
      prmiss   = ($urandom_range(0, 31) == 0);
      if (prmiss) flush_vec = 16'($urandom);
      else if ($urandom_range(0, 63) == 0) flush_vec = 16'($urandom);
      else flush_vec = '0;
      if (c == 1500) begin
        @(negedge clk);
        do_reset();
      end
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iq_entry_alloc.md
Name: iq_entry_alloc

Overview:
- Issue-queue entry allocator: the free-list side of the dispatch-to-issue-queue allocation interface.
- Hands out up to 2 free IQ entry indices per cycle to dispatch and drives iq_entry_num_1/2, invalid1/2 and allocatable_IQ.
- Reclaims entries when the three select ports grant them, and when a misprediction squashes them.
- Sits between the dispatch stage and the issue queue; owns the occupancy state of every IQ entry.

Parameters:
- IQ_ENT_NUM, 16, number of issue-queue entries.
- IQ_ENT_SEL, 4, index width, clog2(IQ_ENT_NUM).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_1  in  1  dispatch slot 1 holds a valid instruction needing an entry.
- req_2  in  1  dispatch slot 2 holds a valid instruction needing an entry.
- stall_DP  in  1  dispatch stalled; no allocation this cycle.
- grant1, grant2, grant3  in  1 each  select port 1/2/3 issued an entry this cycle.
- selected_ent_1, selected_ent_2, selected_ent_3  in  IQ_ENT_SEL each  entry issued on port 1/2/3.
- prmiss  in  1  branch misprediction flush this cycle.
- flush_vec  in  IQ_ENT_NUM  entries squashed by prmiss; bit i = entry i.
- iq_entry_num_1  out  IQ_ENT_SEL  entry offered to slot 1.
- iq_entry_num_2  out  IQ_ENT_SEL  entry offered to slot 2.
- invalid1  out  1  slot 1 not allocated this cycle.
- invalid2  out  1  slot 2 not allocated this cycle.
- allocatable_IQ  out  1  at least 2 free entries.
- free_cnt  out  IQ_ENT_SEL+1  registered count of free entries.
- alloc_err  out  1  sticky protocol error; see Optional Feature.

Behaviour:
- State: free_vec[IQ_ENT_NUM-1:0] (1 = free); free_cnt register; alloc_err register.
- Reset is asynchronous on reset_n low. free_vec goes to all ones, free_cnt to IQ_ENT_NUM, alloc_err to 0. Reset mid-operation discards all occupancy and takes effect immediately.
- iq_entry_num_1 = lowest-index free entry. iq_entry_num_2 = second-lowest free entry. Both are combinational from free_vec.
- If fewer than 2 entries are free, any unavailable index drives 0.
- allocatable_IQ = (free_cnt >= 2), combinational from register.
- Allocation commits only when all of: ~stall_DP, ~prmiss, allocatable_IQ.
  - Commit with req_1: clears free_vec[iq_entry_num_1].
  - Commit with req_2: clears free_vec[iq_entry_num_2].
- Slots are fixed: a slot 2 request always takes the second-lowest entry, even when req_1 = 0. No partial allocation: with free_cnt = 1, neither slot allocates.
- invalid1 = ~(req_1 & commit). invalid2 = ~(req_2 & commit). Both are combinational, same cycle.
- Free: each grantN sets free_vec[selected_ent_N] at the edge. Up to 3 frees per cycle; duplicate indices are harmless.
- Flush: when prmiss = 1, free_vec |= flush_vec. Grants are still applied. Allocation is suppressed that cycle.
- Freed entries become visible next cycle only; no same-cycle free-to-allocate bypass.
- next_free_vec = (free_vec & ~alloc_mask) | free_mask | (prmiss ? flush_vec : 0).
- free_cnt <= popcount(next_free_vec). Width IQ_ENT_SEL+1, so the count can never overflow.
- Alloc and free cannot target the same entry, because an allocated entry was free.
- Full (free_cnt = 0): both outputs invalid. Empty (all free): free_cnt = IQ_ENT_NUM.
- Latency: request to entry index is 0 cycles. An allocated entry shows as busy in free_vec after 1 edge.

Optional Feature:
- Macro: IQ_ENTRY_ALLOC_CHECK_EN.
- Defined: alloc_err sets and stays set until reset on any of:
  - a grant freeing an entry already free in free_vec;
  - flush_vec bit set while prmiss = 0;
  - req_1 or req_2 high with ~stall_DP while allocatable_IQ = 0.
- Undefined: alloc_err is tied to 0 and no check logic is built.

Test Plan:
- Reset: pull reset_n low mid-cycle -> immediately free_cnt = 16, allocatable_IQ = 1, iq_entry_num_1 = 0, iq_entry_num_2 = 1, alloc_err = 0.
- Fill: req_1 = req_2 = 1 with no stall for 8 cycles -> entries 0..15 allocated in pairs, free_cnt = 0, allocatable_IQ = 0. A 9th request -> invalid1 = invalid2 = 1.
- Free: from full, grant1/2/3 on entries 5, 2, 9 -> next cycle free_cnt = 3, iq_entry_num_1 = 2, iq_entry_num_2 = 5. Same-cycle requests see invalid = 1.
- Single free: free_cnt = 1 (entry 7 only), req_1 = 1 -> invalid1 = 1, entry 7 stays free.
- Flush: entries 0..15 busy, prmiss = 1, flush_vec = 16'h00F0, grant1 on entry 12, req_1 = req_2 = 1 -> no allocation, next cycle free_cnt = 5, iq_entry_num_1 = 4, iq_entry_num_2 = 5.
- Check (macro defined): grant1 on an already-free entry 3 -> alloc_err = 1 next cycle and held until reset_n low. With the macro undefined -> alloc_err stays 0.
